// File: rtl/cr16_test_sequencer_if.sv
// Step-ROM and datapath bundle for cr16_test_sequencer.
// master = sequencer side, slave = ROM/datapath side.
interface cr16_test_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 16,
    parameter int PROG_BITS  = 4,
    parameter int STEP_BITS  = 5,
    parameter int OP_BITS    = 8
);
    localparam int RW = $clog2(REG_COUNT);
    localparam int AW = PROG_BITS + STEP_BITS;
    localparam int SW = OP_BITS + 2 * RW + 2 * DATA_WIDTH + 3;

    logic [AW-1:0]         step_addr;
    logic [SW-1:0]         step_word;
    logic [OP_BITS-1:0]    alu_op;
    logic [RW-1:0]         rdest;
    logic [RW-1:0]         rsrc;
    logic [DATA_WIDTH-1:0] imm;
    logic                  imm_sel;
    logic                  reg_wr_en;
    logic [DATA_WIDTH-1:0] alu_result;

    modport master (
        output step_addr, alu_op, rdest, rsrc,
        output imm, imm_sel, reg_wr_en,
        input  step_word, alu_result
    );

    modport slave (
        input  step_addr, alu_op, rdest, rsrc,
        input  imm, imm_sel, reg_wr_en,
        output step_word, alu_result
    );
endinterface

// File: rtl/cr16_test_sequencer.sv
// ROM-driven CR16 datapath test sequencer, 3 cycles per step.
// Optional CR16_SEQ_FAIL_CAPTURE_EN adds fail_addr/fail_data capture.
module cr16_test_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int REG_COUNT    = 16,
    parameter int PROG_BITS    = 4,
    parameter int STEP_BITS    = 5,
    parameter int OP_BITS      = 8,
    parameter int ERR_BITS     = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 enable,
    input  logic                 start,
    input  logic [PROG_BITS-1:0] prog_sel,
    cr16_test_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_BITS-1:0]  err_count
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
    ,
    output logic [PROG_BITS+STEP_BITS-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0]          fail_data
`endif
);
    localparam int RW    = $clog2(REG_COUNT);
    localparam int SW    = OP_BITS + 2 * RW + 2 * DATA_WIDTH + 3;
    localparam int B_EXP = 3;
    localparam int B_IMM = B_EXP + DATA_WIDTH;
    localparam int B_RS  = B_IMM + DATA_WIDTH;
    localparam int B_RD  = B_RS + RW;
    localparam int B_OP  = B_RD + RW;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_NEXT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [STEP_BITS-1:0]  idx_q, idx_d;
    logic [PROG_BITS-1:0]  prog_q, prog_d;
    logic [SW-1:0]         step_q, step_d;
    logic [ERR_BITS-1:0]   err_q, err_d;
    logic                  pass_q, pass_d;
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
    logic [PROG_BITS+STEP_BITS-1:0] fa_q, fa_d;
    logic [DATA_WIDTH-1:0]          fd_q, fd_d;
`endif

    logic                  f_last, f_check, f_isel;
    logic [DATA_WIDTH-1:0] f_exp, f_imm;
    logic [RW-1:0]         f_rs, f_rd;
    logic [OP_BITS-1:0]    f_op;
    logic                  mismatch;

    assign f_last  = step_q[0];
    assign f_check = step_q[1];
    assign f_isel  = step_q[2];
    assign f_exp   = step_q[B_EXP +: DATA_WIDTH];
    assign f_imm   = step_q[B_IMM +: DATA_WIDTH];
    assign f_rs    = step_q[B_RS +: RW];
    assign f_rd    = step_q[B_RD +: RW];
    assign f_op    = step_q[B_OP +: OP_BITS];

    assign mismatch = f_check && (bus.alu_result != f_exp);

    assign bus.step_addr = {prog_q, idx_q};
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC)
                    || (state_q == S_NEXT);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
    assign fail_addr = fa_q;
    assign fail_data = fd_q;
`endif

    // State and step bookkeeping registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            prog_q  <= '0;
            step_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b1;
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
            fa_q    <= '0;
            fd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prog_q  <= prog_d;
            step_q  <= step_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
            fa_q    <= fa_d;
            fd_q    <= fd_d;
`endif
        end
    end

    // Next-state, datapath drive and result scoring; enable=0 freezes all
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        prog_d        = prog_q;
        step_d        = step_q;
        err_d         = err_q;
        pass_d        = pass_q;
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
        fa_d          = fa_q;
        fd_d          = fd_q;
`endif
        bus.alu_op    = '0;
        bus.rdest     = '0;
        bus.rsrc      = '0;
        bus.imm       = '0;
        bus.imm_sel   = 1'b0;
        bus.reg_wr_en = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && enable) begin
                    prog_d  = prog_sel;
                    idx_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b1;
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
                    fa_d    = '0;
                    fd_d    = '0;
`endif
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (enable) begin
                    step_d  = bus.step_word;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.alu_op    = f_op;
                bus.rdest     = f_rd;
                bus.rsrc      = f_rs;
                bus.imm       = f_imm;
                bus.imm_sel   = f_isel;
                bus.reg_wr_en = enable;
                if (enable) begin
                    if (mismatch) begin
                        if (err_q != {ERR_BITS{1'b1}})
                            err_d = err_q + 1'b1;
                        pass_d = 1'b0;
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
                        if (pass_q) begin
                            fa_d = bus.step_addr;
                            fd_d = bus.alu_result;
                        end
`endif
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (enable) begin
                    if (f_last || (idx_q == {STEP_BITS{1'b1}})
                        || ((STOP_ON_FAIL != 0) && !pass_q)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (enable)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cr16_test_sequencer.sv
// Scoreboard bench for cr16_test_sequencer: three instances
// (default, STOP_ON_FAIL=1, ERR_BITS=2) share one stimulus stream.
module tb_cr16_test_sequencer;
    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic [3:0] prog_sel = 4'd0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu(input logic [7:0] op,
                                        input logic [15:0] im);
        return im + 16'(op);
    endfunction

    function automatic logic [50:0] rom(input logic [8:0] a);
        logic [3:0]  p;
        logic [4:0]  i;
        logic [7:0]  op;
        logic [15:0] im;
        logic [15:0] ex;
        logic        lst;
        p  = a[8:5];
        i  = a[4:0];
        op = 8'(i) + 8'd1;
        im = 16'(i) * 16'h10 + 16'(p);
        if (p == 4'd5 && i == 5'd1) begin
            op = 8'd1;
            im = 16'd4;
        end
        ex = alu(op, im);
        if ((p == 4'd5 && i == 5'd1) ||
            (p == 4'd7 && (i == 5'd3 || i == 5'd9 || i == 5'd15 ||
                           i == 5'd21 || i == 5'd27)))
            ex = ex + 16'd1;
        case (p)
            4'd3, 4'd5: lst = (i == 5'd3);
            4'd7:       lst = 1'b0;
            default:    lst = (i == 5'd0);
        endcase
        return {op, i[3:0], p, im, ex, i[0], 1'b1, lst};
    endfunction

    cr16_test_sequencer_if if0 ();
    cr16_test_sequencer_if if1 ();
    cr16_test_sequencer_if if2 ();

    assign if0.step_word  = rom(if0.step_addr);
    assign if1.step_word  = rom(if1.step_addr);
    assign if2.step_word  = rom(if2.step_addr);
    assign if0.alu_result = alu(if0.alu_op, if0.imm);
    assign if1.alu_result = alu(if1.alu_op, if1.imm);
    assign if2.alu_result = alu(if2.alu_op, if2.imm);

    logic [2:0] busy_w, done_w, pass_w, wr_w;
    logic [7:0] err0, err1;
    logic [1:0] err2;
    assign wr_w = {if2.reg_wr_en, if1.reg_wr_en, if0.reg_wr_en};
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
    logic [8:0]  fa0, fa1, fa2;
    logic [15:0] fd0, fd1, fd2;
`endif

    cr16_test_sequencer u0 (
        .clk(clk), .nrst(nrst), .enable(enable), .start(start),
        .prog_sel(prog_sel), .bus(if0), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]), .err_count(err0)
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
        , .fail_addr(fa0), .fail_data(fd0)
`endif
    );

    cr16_test_sequencer #(.STOP_ON_FAIL(1)) u1 (
        .clk(clk), .nrst(nrst), .enable(enable), .start(start),
        .prog_sel(prog_sel), .bus(if1), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]), .err_count(err1)
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
        , .fail_addr(fa1), .fail_data(fd1)
`endif
    );

    cr16_test_sequencer #(.ERR_BITS(2)) u2 (
        .clk(clk), .nrst(nrst), .enable(enable), .start(start),
        .prog_sel(prog_sel), .bus(if2), .busy(busy_w[2]),
        .done(done_w[2]), .pass(pass_w[2]), .err_count(err2)
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
        , .fail_addr(fa2), .fail_data(fd2)
`endif
    );

    typedef struct {
        int addr;
        int cyc;
    } wr_t;

    typedef struct {
        int pass;
        int err;
        int nwr;
        int cyc;
        int fa;
        int fd;
    } res_t;

    wr_t  wrq[$];
    res_t resq[3][$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   nwr[3];
    int   done_cnt[3];
    bit   dq[3];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: event had no expectation", nm);
    endtask

    function automatic int err_of(input int i);
        case (i)
            0:       return int'(err0);
            1:       return int'(err1);
            default: return int'(err2);
        endcase
    endfunction

    task automatic push_res(input int i, input int p, input int e,
                            input int n, input int c,
                            input int fa, input int fd);
        res_t r;
        r.pass = p; r.err = e; r.nwr = n; r.cyc = c;
        r.fa = fa; r.fd = fd;
        resq[i].push_back(r);
    endtask

    task automatic push_wr(input int a, input int c);
        wr_t w;
        w.addr = a; w.cyc = c;
        wrq.push_back(w);
    endtask

    // Monitor: writes on u0 and done pulses on all three instances
    initial begin
        wr_t  w;
        res_t r;
        for (int i = 0; i < 3; i++) begin
            nwr[i] = 0; done_cnt[i] = 0; dq[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!nrst) begin
                    nwr[i] = 0;
                    dq[i]  = 1'b0;
                end else begin
                    if (wr_w[i]) begin
                        nwr[i]++;
                        if (i == 0) begin
                            if (wrq.size() == 0) begin
                                fail_now("wr_unexpected");
                            end else begin
                                w = wrq.pop_front();
                                chk("wr_addr", int'(if0.step_addr), w.addr);
                                if (w.cyc >= 0)
                                    chk("wr_cycle", cyc, w.cyc);
                            end
                        end
                    end
                    if (done_w[i] && !dq[i]) begin
                        done_cnt[i]++;
                        if (resq[i].size() == 0) begin
                            fail_now($sformatf("done_unexpected_u%0d", i));
                        end else begin
                            r = resq[i].pop_front();
                            chk($sformatf("pass_u%0d", i),
                                int'(pass_w[i]), r.pass);
                            chk($sformatf("err_u%0d", i), err_of(i), r.err);
                            chk($sformatf("nwr_u%0d", i), nwr[i], r.nwr);
                            if (r.cyc >= 0)
                                chk($sformatf("done_cyc_u%0d", i), cyc, r.cyc);
`ifdef CR16_SEQ_FAIL_CAPTURE_EN
                            if (i == 0) begin
                                chk("fail_addr", int'(fa0), r.fa);
                                chk("fail_data", int'(fd0), r.fd);
                            end
`endif
                        end
                        nwr[i] = 0;
                    end
                    dq[i] = done_w[i];
                end
            end
        end
    end

    int base;

    task automatic launch(input logic [3:0] p, output int t);
        @(posedge clk);
        #1;
        t        = cyc;
        base     = done_cnt[0];
        prog_sel = p;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk);
            if (done_cnt[0] > base) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic plain_prog3();
        int t;
        launch(4'd3, t);
        for (int k = 0; k < 4; k++) push_wr(9'h60 + k, t + 2 + 3 * k);
        push_res(0, 1, 0, 4, t + 13, 0, 0);
        push_res(1, 1, 0, 4, -1, 0, 0);
        push_res(2, 1, 0, 4, -1, 0, 0);
        wait_done();
    endtask

    // Directed stimulus
    initial begin
        int t;
        #1 nrst = 1'b0;
        #2;
        chk("rst_addr", int'(if0.step_addr), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_done", int'(done_w[0]), 0);
        chk("rst_pass", int'(pass_w[0]), 1);
        chk("rst_err", int'(err0), 0);
        chk("rst_wr", int'(if0.reg_wr_en), 0);
        chk("rst_op", int'(if0.alu_op), 0);
        repeat (2) @(posedge clk);
        #1;
        nrst   = 1'b1;
        enable = 1'b1;

        plain_prog3();

        launch(4'd5, t);
        for (int k = 0; k < 4; k++) push_wr(9'hA0 + k, t + 2 + 3 * k);
        push_res(0, 0, 1, 4, t + 13, 9'hA1, 16'h0005);
        push_res(1, 0, 1, 2, t + 7, 0, 0);
        push_res(2, 0, 1, 4, -1, 0, 0);
        wait_done();

        launch(4'd3, t);
        push_wr(9'h60, t + 2);
        push_wr(9'h61, t + 10);
        push_wr(9'h62, t + 13);
        push_wr(9'h63, t + 16);
        push_res(0, 1, 0, 4, t + 18, 0, 0);
        push_res(1, 1, 0, 4, -1, 0, 0);
        push_res(2, 1, 0, 4, -1, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_wr", int'(if0.reg_wr_en), 0);
            chk("stall_addr", int'(if0.step_addr), 9'h61);
            chk("stall_busy", int'(busy_w[0]), 1);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_done", int'(done_w[0]), 1);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_done();

        launch(4'd7, t);
        for (int k = 0; k < 32; k++) push_wr(9'hE0 + k, t + 2 + 3 * k);
        push_res(0, 0, 5, 32, t + 97, 9'hE3, 16'h003B);
        push_res(1, 0, 1, 4, -1, 0, 0);
        push_res(2, 0, 3, 32, -1, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        prog_sel = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        wait_done();

        launch(4'd3, t);
        push_wr(9'h60, t + 2);
        push_wr(9'h61, t + 5);
        repeat (6) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_w[0]), 0);
        chk("mid_rst_done", int'(done_w[0]), 0);
        chk("mid_rst_addr", int'(if0.step_addr), 0);
        chk("mid_rst_wr", int'(if0.reg_wr_en), 0);
        chk("mid_rst_busy_u1", int'(busy_w[1]), 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", int'(busy_w[0]), 0);

        plain_prog3();

        chk("wrq_empty", wrq.size(), 0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("resq_empty_u%0d", i), resq[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
